// File: rtl/mem_req_ctrl.sv
// Memory-stage request generator: latches one load/store from EX, drives the
// data cache request handshake, and returns aligned/extended load data to writeback.
module mem_req_ctrl #(
   parameter int unsigned TAG_W    = 20,
   parameter int unsigned INDEX_W  = 7,
   parameter int unsigned OFFSET_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ex_valid,
   input  logic                ex_load,
   input  logic                ex_store,
   input  logic [2:0]          ex_type,
   input  logic [31:0]         ex_addr,
   input  logic [31:0]         ex_wdata,
   input  logic                ex_cached,
   input  logic                ex_cancel,
   output logic                ex_ready,
   output logic                ex_ale,
   input  logic                flush,
   output logic                data_req,
   output logic [1:0]          data_size,
   output logic                data_op,
   output logic [TAG_W-1:0]    data_tag,
   output logic [INDEX_W-1:0]  data_index,
   output logic [OFFSET_W-1:0] data_offset,
   output logic [3:0]          data_wstrb,
   output logic [31:0]         data_wdata,
   output logic                data_cache,
   input  logic                data_addr_ok,
   input  logic                data_data_ok,
   input  logic [31:0]         data_rdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [31:0]         resp_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [2:0]  type_q;
   logic        op_q;
   logic [1:0]  size_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;
   logic        cache_q;
   logic        cancel_q, cancel_d;
   logic [31:0] resp_rdata_q;
   logic        resp_load;

   logic        is_mem;
   logic        accept;
   logic [1:0]  ex_size;
   logic [3:0]  ex_wstrb;
   logic [31:0] ex_wdata_rep;
   logic [31:0] shifted;
   logic [31:0] load_data;

   assign is_mem = ex_valid & (ex_load | ex_store);

   always_comb begin
      ex_ale = 1'b0;
      if (is_mem) begin
         if (ex_type[1:0] == 2'b01)      ex_ale = ex_addr[0];
         else if (ex_type[1:0] == 2'b10) ex_ale = |ex_addr[1:0];
      end
   end

   assign ex_ready = (state_q == StIdle);
   assign accept   = ex_ready & is_mem & ~ex_cancel & ~ex_ale & ~flush;

   always_comb begin
      ex_size      = 2'd2;
      ex_wstrb     = 4'b1111;
      ex_wdata_rep = ex_wdata;
      case (ex_type[1:0])
         2'b00: begin
            ex_size      = 2'd0;
            ex_wstrb     = 4'b0001 << ex_addr[1:0];
            ex_wdata_rep = {4{ex_wdata[7:0]}};
         end
         2'b01: begin
            ex_size      = 2'd1;
            ex_wstrb     = ex_addr[1] ? 4'b1100 : 4'b0011;
            ex_wdata_rep = {2{ex_wdata[15:0]}};
         end
         default: ;
      endcase
      if (!ex_store) ex_wstrb = 4'b0000;
   end

   assign shifted = data_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_data = shifted;
      case (type_q)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
      if (op_q) load_data = 32'd0;
   end

   // A flush may not withdraw a visible request; it only marks the result for discard.
   always_comb begin
      state_d   = state_q;
      cancel_d  = cancel_q;
      resp_load = 1'b0;
      data_req  = 1'b0;
      resp_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            cancel_d = 1'b0;
            if (accept) state_d = StReq;
         end
         StReq: begin
            data_req = 1'b1;
            if (flush) cancel_d = 1'b1;
            if (data_addr_ok) state_d = StWait;
         end
         StWait: begin
            if (flush) cancel_d = 1'b1;
            if (data_data_ok) begin
               if (cancel_q || flush) begin
                  cancel_d = 1'b0;
                  state_d  = StIdle;
               end else begin
                  resp_load = 1'b1;
                  state_d   = StResp;
               end
            end
         end
         StResp: begin
            resp_valid = 1'b1;
            if (flush || resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         addr_q       <= 32'd0;
         type_q       <= 3'd0;
         op_q         <= 1'b0;
         size_q       <= 2'd0;
         wstrb_q      <= 4'd0;
         wdata_q      <= 32'd0;
         cache_q      <= 1'b0;
         cancel_q     <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         if (accept) begin
            addr_q  <= ex_addr;
            type_q  <= ex_type;
            op_q    <= ex_store;
            size_q  <= ex_size;
            wstrb_q <= ex_wstrb;
            wdata_q <= ex_wdata_rep;
            cache_q <= ex_cached;
         end
         if (resp_load) resp_rdata_q <= load_data;
      end
   end

   assign data_size   = size_q;
   assign data_op     = op_q;
   assign data_tag    = addr_q[31:INDEX_W+OFFSET_W];
   assign data_index  = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign data_offset = addr_q[OFFSET_W-1:0];
   assign data_wstrb  = wstrb_q;
   assign data_wdata  = wdata_q;
   assign data_cache  = cache_q;
   assign resp_rdata  = resp_rdata_q;

endmodule
